axi_write_master: RTL and testbench
===================================

AXI_WRITE_MASTER -- requirements
Module: axi_write_master

Interface
REQ-001 SHALL have parameter WR_ID, default 4'd1, the fixed AWID driven on every write transaction.
REQ-002 SHALL have parameter ADDR_W, default 64, the address width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit, reset: asynchronous assert, active-low.
REQ-005 SHALL have port mm_wen, input, 1 bit, store request from the memory stage.
REQ-006 SHALL have port mm_addr, input, ADDR_W bits, store byte address.
REQ-007 SHALL have port mm_wdata, input, 64 bits, store data, LSB-aligned.
REQ-008 SHALL have port mm_wlen, input, 4 bits, store size in bytes (1, 2, 4 or 8).
REQ-009 SHALL have port wr_ready, output, 1 bit, high when a request can be accepted.
REQ-010 SHALL have port wr_done, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port wr_err, output, 1 bit, one-cycle pulse on a bad response or an illegal request.
REQ-012 SHALL have AXI write-address ports: AWID[3:0], AWADDR[ADDR_W-1:0], AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWVALID (all outputs) and AWREADY (input).
REQ-013 SHALL have AXI write-data ports: WDATA[63:0], WSTRB[7:0], WLAST, WVALID (all outputs) and WREADY (input).
REQ-014 SHALL have AXI write-response ports: BID[3:0], BRESP[1:0], BVALID (all inputs) and BREADY (output).

Function
REQ-015 SHALL implement FSM states IDLE, ADDR_DATA and RESP; wr_ready = (state==IDLE).
REQ-016 Accept rule: a request is accepted when mm_wen && wr_ready; mm_* are sampled into registers on that edge; inputs are ignored outside IDLE.
REQ-017 Legality: a request is legal iff mm_wlen ∈ {1,2,4,8} and mm_addr[2:0]+mm_wlen ≤ 8.
REQ-018 Illegal accepted request: no AXI traffic; wr_err pulses the next cycle; state stays IDLE.
REQ-019 Legal accepted request: transition to ADDR_DATA; AWVALID and WVALID both assert in the first cycle after acceptance.
REQ-020 AWADDR = mm_addr; AWLEN = 0; AWBURST = 2'b01 (INCR); AWSIZE = log2(mm_wlen); AWID = WR_ID; WLAST = 1.
REQ-021 WSTRB = ((1<<mm_wlen)-1) << mm_addr[2:0].
REQ-022 WDATA = mm_wdata << (8*mm_addr[2:0]), truncated to 64 bits.
REQ-023 AWVALID drops on the cycle after its AWREADY handshake; WVALID drops on the cycle after its WREADY handshake; the two are tracked independently, in either order or simultaneously.
REQ-024 Payloads SHALL remain stable while the corresponding VALID is high; a VALID never deasserts before its handshake.
REQ-025 ADDR_DATA→RESP when both handshakes have completed, including both in the same cycle.
REQ-026 RESP: BREADY=1; BREADY=0 in all other states.
REQ-027 On BVALID in RESP: return to IDLE; next cycle wr_done=1, and wr_err=1 iff BRESP≠2'b00 or BID≠WR_ID.
REQ-028 Latency with an always-ready slave: acceptance at cycle N, AW/W handshake at N+1, B at N+2, wr_done at N+3; back-to-back acceptance possible at N+3.
REQ-029 BVALID SHALL be ignored outside RESP.
REQ-030 At most one outstanding transaction.

Reset
REQ-031 rstn low SHALL asynchronously force state=IDLE and AWVALID=WVALID=BREADY=wr_done=wr_err=0, wr_ready=1, and all payload registers to 0.
REQ-032 Reset mid-transaction SHALL abandon it with no wr_done; operation resumes on the first edge after rstn rises.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the AXI burst/response encodings (INCR, OKAY, SLVERR, DECERR) and the size-to-AWSIZE mapping.
REQ-034 Strobe and data alignment SHALL be a combinational sub-module wstrb_align (inputs addr[2:0], len, data; outputs strb, aligned data).

Verification
REQ-035 Scenario, aligned doubleword: addr=0x8000_0008, len=8, data=0x1122334455667788, ready slave → AWSIZE=3, WSTRB=0xFF, WDATA unchanged, wr_done at N+3, wr_err=0.
REQ-036 Scenario, byte store: addr=0x8000_0003, len=1, data=0xAB → WSTRB=0x08, WDATA[31:24]=0xAB, AWSIZE=0.
REQ-037 Scenario, ready skew: WREADY 3 cycles before AWREADY → WVALID drops first, AWVALID held stable, BREADY rises only after both handshakes.
REQ-038 Scenario, illegal requests: addr=0x...6 with len=4, and len=3 → no AWVALID/WVALID; wr_err pulses once; wr_ready stays 1.
REQ-039 Scenario, slave error: BRESP=2'b10 → wr_done and wr_err pulse together.
REQ-040 Scenario, reset mid-operation: rstn low during ADDR_DATA with AWVALID=1 → AWVALID=0 immediately without waiting for clk; no wr_done after release.

Source files
------------

// File: rtl/axi_write_master_pkg.sv
// Shared types and encodings for the single-beat AXI write master.
package axi_write_master_pkg;

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [2:0] len_to_awsize(input logic [3:0] len);
    case (len)
      4'd1:    return 3'd0;
      4'd2:    return 3'd1;
      4'd4:    return 3'd2;
      4'd8:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  // Legal sizes are powers of two up to 8 that do not straddle a doubleword.
  function automatic logic req_legal(input logic [3:0] len, input logic [2:0] off);
    logic len_ok;
    len_ok = (len == 4'd1) || (len == 4'd2) || (len == 4'd4) || (len == 4'd8);
    return len_ok && (({2'b00, off} + {1'b0, len}) <= 5'd8);
  endfunction

endpackage

// File: rtl/wstrb_align.sv
// Places an LSB-aligned store onto the 64-bit data lane and builds its byte strobe.
module wstrb_align (
  input  logic [2:0]  addr,
  input  logic [3:0]  len,
  input  logic [63:0] data,
  output logic [7:0]  strb,
  output logic [63:0] aligned
);

  logic [7:0] w_mask;

  always_comb begin
    w_mask = 8'h00;
    case (len)
      4'd1:    w_mask = 8'h01;
      4'd2:    w_mask = 8'h03;
      4'd4:    w_mask = 8'h0F;
      4'd8:    w_mask = 8'hFF;
      default: w_mask = 8'h00;
    endcase
  end

  assign strb    = w_mask << addr;
  assign aligned = data << {addr, 3'b000};

endmodule

// File: rtl/axi_write_master.sv
// Single-outstanding, single-beat AXI4 write master fed by the memory stage.
module axi_write_master #(
  parameter logic [3:0]  WR_ID  = 4'd1,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mm_wen,
  input  logic [ADDR_W-1:0] mm_addr,
  input  logic [63:0]       mm_wdata,
  input  logic [3:0]        mm_wlen,
  output logic              wr_ready,
  output logic              wr_done,
  output logic              wr_err,
  output logic [3:0]        AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [63:0]       WDATA,
  output logic [7:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [3:0]        BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);
  import axi_write_master_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_awaddr;
  logic [2:0]        r_awsize;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_done;
  logic              r_err;

  logic [7:0]        w_strb;
  logic [63:0]       w_data;
  logic              w_legal;
  logic              w_aw_ok;
  logic              w_w_ok;

  wstrb_align u_align (
    .addr    (mm_addr[2:0]),
    .len     (mm_wlen),
    .data    (mm_wdata),
    .strb    (w_strb),
    .aligned (w_data)
  );

  assign w_legal = req_legal(mm_wlen, mm_addr[2:0]);
  // A channel is finished once its VALID has dropped or is handshaking now.
  assign w_aw_ok = !r_awvalid || AWREADY;
  assign w_w_ok  = !r_wvalid || WREADY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_awaddr  <= '0;
      r_awsize  <= 3'd0;
      r_wdata   <= 64'd0;
      r_wstrb   <= 8'd0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mm_wen) begin
            if (w_legal) begin
              r_awaddr  <= mm_addr;
              r_awsize  <= len_to_awsize(mm_wlen);
              r_wdata   <= w_data;
              r_wstrb   <= w_strb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ADDR_DATA;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ADDR_DATA: begin
          if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && WREADY)   r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_state  <= RESP;
            r_bready <= 1'b1;
          end
        end
        RESP: begin
          if (BVALID) begin
            r_state  <= IDLE;
            r_bready <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= (BRESP != RESP_OKAY) || (BID != WR_ID);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ready = (r_state == IDLE);
  assign wr_done  = r_done;
  assign wr_err   = r_err;
  assign AWID     = WR_ID;
  assign AWADDR   = r_awaddr;
  assign AWLEN    = 8'd0;
  assign AWSIZE   = r_awsize;
  assign AWBURST  = BURST_INCR;
  assign AWVALID  = r_awvalid;
  assign WDATA    = r_wdata;
  assign WSTRB    = r_wstrb;
  assign WLAST    = 1'b1;
  assign WVALID   = r_wvalid;
  assign BREADY   = r_bready;

endmodule

// File: tb/tb_axi_write_master.sv
// Directed bench for axi_write_master with a scoreboard of expected write beats.
module tb_axi_write_master;
  import axi_write_master_pkg::*;

  logic        clk, rstn;
  logic        mm_wen;
  logic [63:0] mm_addr;
  logic [63:0] mm_wdata;
  logic [3:0]  mm_wlen;
  logic        wr_ready, wr_done, wr_err;
  logic [3:0]  AWID;
  logic [63:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_err = 0;
  logic saw;

  axi_write_master #(.WR_ID(4'd1), .ADDR_W(64)) dut (
    .clk(clk), .rstn(rstn), .mm_wen(mm_wen), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_wlen(mm_wlen), .wr_ready(wr_ready), .wr_done(wr_done), .wr_err(wr_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drive one request for a single cycle; returns in the cycle after acceptance.
  task automatic issue(input logic [63:0] a, input logic [3:0] len, input logic [63:0] d);
    chk("ready_before_issue", wr_ready, 1'b1);
    mm_wen = 1'b1; mm_addr = a; mm_wlen = len; mm_wdata = d;
    cyc();
    mm_wen = 1'b0; mm_addr = 64'd0; mm_wlen = 4'd0; mm_wdata = 64'd0;
  endtask

  task automatic check_aw();
    for (int i = 0; i < 20 && !AWVALID; i++) cyc();
    chk("awvalid_seen", AWVALID, 1'b1);
    if (sb.size() == 0) begin
      n_chk++; n_err++;
      $error("FAIL sb_empty: observed=empty expected=entry");
    end else begin
      cur = sb.pop_front();
      chk("awaddr", AWADDR, cur.addr);
      chk("awsize", AWSIZE, cur.size);
      chk("wstrb", WSTRB, cur.strb);
      chk("wdata", WDATA, cur.data);
      chk("awlen", AWLEN, 8'd0);
      chk("awburst", AWBURST, 2'b01);
      chk("awid", AWID, 4'd1);
      chk("wlast", WLAST, 1'b1);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !wr_done; i++) cyc();
    chk("wr_done", wr_done, 1'b1);
    chk("wr_err_with_done", wr_err, cur.err);
    cyc();
    chk("wr_done_pulse", wr_done, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; mm_wen = 1'b0; mm_addr = 64'd0; mm_wdata = 64'd0; mm_wlen = 4'd0;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = RESP_OKAY; BID = 4'd1;
    cyc(); cyc();
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_bready", BREADY, 1'b0);
    chk("rst_done_err", {wr_done, wr_err}, 2'b00);
    chk("rst_payload", {AWADDR, WDATA, WSTRB}, '0);
    rstn = 1'b1;
    cyc();

    // Aligned doubleword with exact cycle-by-cycle latency.
    sb.push_back('{64'h0000_0000_8000_0008, 3'd3, 8'hFF, 64'h1122334455667788, 1'b0});
    issue(64'h0000_0000_8000_0008, 4'd8, 64'h1122334455667788);
    chk("n1_awvalid", AWVALID, 1'b1);
    chk("n1_wvalid", WVALID, 1'b1);
    chk("n1_not_ready", wr_ready, 1'b0);
    check_aw();
    cyc();
    chk("n2_bready", BREADY, 1'b1);
    chk("n2_valids_low", {AWVALID, WVALID}, 2'b00);
    chk("n2_no_done", wr_done, 1'b0);
    cyc();
    chk("n3_done", wr_done, 1'b1);
    chk("n3_err", wr_err, 1'b0);
    chk("n3_bready_low", BREADY, 1'b0);

    // Byte store issued back-to-back at N+3.
    sb.push_back('{64'h0000_0000_8000_0003, 3'd0, 8'h08, 64'h0000_0000_AB00_0000, 1'b0});
    issue(64'h0000_0000_8000_0003, 4'd1, 64'h0000_0000_0000_00AB);
    check_aw();
    wait_done();

    // Halfword at top of lane, word with upper garbage truncated away.
    sb.push_back('{64'h0000_0000_1000_0006, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0});
    issue(64'h0000_0000_1000_0006, 4'd2, 64'h0000_0000_0000_BEEF);
    check_aw();
    wait_done();
    sb.push_back('{64'h0000_0000_1000_0004, 3'd2, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b0});
    issue(64'h0000_0000_1000_0004, 4'd4, 64'hFFFF_FFFF_DEAD_BEEF);
    check_aw();
    wait_done();

    // W handshakes three cycles before AW.
    AWREADY = 1'b0;
    sb.push_back('{64'h0000_0000_2000_0000, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0});
    issue(64'h0000_0000_2000_0000, 4'd8, 64'h0123_4567_89AB_CDEF);
    check_aw();
    cyc();
    chk("skew_wvalid_drop", WVALID, 1'b0);
    chk("skew_awvalid_held", AWVALID, 1'b1);
    chk("skew_bready_wait", BREADY, 1'b0);
    cyc();
    chk("skew_awaddr_stable", AWADDR, 64'h0000_0000_2000_0000);
    chk("skew_bready_wait2", BREADY, 1'b0);
    cyc();
    AWREADY = 1'b1;
    chk("skew_awvalid_held2", AWVALID, 1'b1);
    cyc();
    chk("skew_awvalid_drop", AWVALID, 1'b0);
    chk("skew_bready_up", BREADY, 1'b1);
    wait_done();

    // Illegal requests: straddling word and non-power-of-two size.
    issue(64'h0000_0000_8000_0006, 4'd4, 64'h1);
    chk("ill1_err", wr_err, 1'b1);
    chk("ill1_no_axi", {AWVALID, WVALID}, 2'b00);
    chk("ill1_ready", wr_ready, 1'b1);
    chk("ill1_no_done", wr_done, 1'b0);
    cyc();
    chk("ill1_err_pulse", wr_err, 1'b0);
    issue(64'h0000_0000_8000_0000, 4'd3, 64'h2);
    chk("ill2_err", wr_err, 1'b1);
    chk("ill2_no_axi", {AWVALID, WVALID}, 2'b00);
    chk("ill2_ready", wr_ready, 1'b1);
    cyc();
    chk("ill2_err_pulse", wr_err, 1'b0);

    // Error responses: SLVERR, DECERR, mismatched BID.
    BRESP = RESP_SLVERR;
    sb.push_back('{64'h0000_0000_3000_0000, 3'd3, 8'hFF, 64'h5555_AAAA_5555_AAAA, 1'b1});
    issue(64'h0000_0000_3000_0000, 4'd8, 64'h5555_AAAA_5555_AAAA);
    check_aw();
    wait_done();
    BRESP = RESP_DECERR;
    sb.push_back('{64'h0000_0000_3000_0001, 3'd0, 8'h02, 64'h0000_0000_0000_5A00, 1'b1});
    issue(64'h0000_0000_3000_0001, 4'd1, 64'h0000_0000_0000_005A);
    check_aw();
    wait_done();
    BRESP = RESP_OKAY; BID = 4'd2;
    sb.push_back('{64'h0000_0000_3000_0002, 3'd1, 8'h0C, 64'h0000_0000_1234_0000, 1'b1});
    issue(64'h0000_0000_3000_0002, 4'd2, 64'h0000_0000_0000_1234);
    check_aw();
    wait_done();
    BID = 4'd1;

    // Asynchronous reset while AWVALID is up.
    AWREADY = 1'b0; WREADY = 1'b0;
    issue(64'h0000_0000_4000_0000, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rmid_awvalid", AWVALID, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk("rmid_async_awvalid", AWVALID, 1'b0);
    chk("rmid_async_wvalid", WVALID, 1'b0);
    chk("rmid_async_ready", wr_ready, 1'b1);
    cyc();
    rstn = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      saw = saw | wr_done | AWVALID;
    end
    chk("rmid_no_done", saw, 1'b0);
    sb.push_back('{64'h0000_0000_4000_0010, 3'd3, 8'hFF, 64'hCAFE_F00D_CAFE_F00D, 1'b0});
    issue(64'h0000_0000_4000_0010, 4'd8, 64'hCAFE_F00D_CAFE_F00D);
    check_aw();
    wait_done();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
